// File: rtl/tt_in_debounce.sv
// ============================================================================
// Module   : tt_in_debounce
// Purpose  : Pad-input front end for the TT core. Synchronises the raw pad
//            word, debounces it as a whole, and queues each newly settled
//            value as a single valid/ready event. Dropped events raise a
//            sticky overflow flag.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tt_in_debounce #(
  parameter int WIDTH      = 8,
  parameter int DEB_CYCLES = 16,
  parameter int FIFO_DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] io_i_raw,
  output logic [WIDTH-1:0] o_stable,
  output logic [WIDTH-1:0] o_data,
  output logic             o_valid,
  input  logic             i_ready,
  output logic             o_ovf,
  input  logic             i_ovf_clr
);

  // Counter only has to reach DEB_CYCLES-1; FIFO pointers wrap naturally
  // because the depth is a power of two.
  localparam int CW = (DEB_CYCLES > 2) ? $clog2(DEB_CYCLES) : 1;
  localparam int AW = (FIFO_DEPTH > 2) ? $clog2(FIFO_DEPTH) : 1;
  localparam int NW = AW + 1;
  localparam logic [CW-1:0] C_CNT_MAX = CW'(DEB_CYCLES - 1);
  localparam logic [NW-1:0] C_FULL    = NW'(FIFO_DEPTH);

  // Synchroniser, debounce and FIFO state
  logic [WIDTH-1:0] s1_q, s2_q;
  logic [WIDTH-1:0] cand_q, cand_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] stable_q, stable_d;
  logic [WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [NW-1:0]    count_q, count_d;
  logic             ovf_q, ovf_d;

  logic push;   // debouncer has a new settled value this cycle
  logic pop;    // consumer takes the head entry this cycle
  logic full;
  logic wr_en;  // push actually stored
  logic drop;   // push lost because the FIFO is full and not draining

  // Two-flop synchroniser on the whole pad word
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_q <= '0;
      s2_q <= '0;
    end else begin
      s1_q <= io_i_raw;
      s2_q <= s1_q;
    end
  end

  // Word-level debounce: restart on any change, commit once the count saturates
  always_comb begin
    cand_d   = cand_q;
    cnt_d    = cnt_q;
    stable_d = stable_q;
    push     = 1'b0;
    if (s2_q != cand_q) begin
      cand_d = s2_q;
      cnt_d  = '0;
    end else if (cnt_q != C_CNT_MAX) begin
      cnt_d = cnt_q + 1'b1;
    end else if (cand_q != stable_q) begin
      stable_d = cand_q;
      push     = 1'b1;
    end
  end

  // FIFO control: simultaneous push and pop on a full FIFO is not an overflow
  always_comb begin
    pop      = (count_q != '0) && i_ready;
    full     = (count_q == C_FULL);
    wr_en    = push && (!full || pop);
    drop     = push && full && !pop;
    wr_ptr_d = wr_en ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop   ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d  = count_q;
    if (wr_en && !pop) begin
      count_d = count_q + 1'b1;
    end else if (!wr_en && pop) begin
      count_d = count_q - 1'b1;
    end
    // A drop on the same edge as a clear leaves the flag set
    if (drop) begin
      ovf_d = 1'b1;
    end else if (i_ovf_clr) begin
      ovf_d = 1'b0;
    end else begin
      ovf_d = ovf_q;
    end
  end

  // Debounce and FIFO state registers; reset clears queued events too
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cand_q   <= '0;
      cnt_q    <= '0;
      stable_q <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      cand_q   <= cand_d;
      cnt_q    <= cnt_d;
      stable_q <= stable_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      if (wr_en) begin
        mem_q[wr_ptr_q] <= stable_d;
      end
    end
  end

  // All outputs come straight from registers
  assign o_stable = stable_q;
  assign o_data   = mem_q[rd_ptr_q];
  assign o_valid  = (count_q != '0);
  assign o_ovf    = ovf_q;

endmodule

`default_nettype wire

// File: tb/tb_tt_in_debounce.sv
// ============================================================================
// Module   : tb_tt_in_debounce
// Purpose  : Directed, table-driven self-checking bench for tt_in_debounce
//            with default parameters (WIDTH=8, DEB_CYCLES=16, FIFO_DEPTH=2).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_tt_in_debounce;

  logic       clk;
  logic       rst_n;
  logic [7:0] io_i_raw;
  logic [7:0] o_stable;
  logic [7:0] o_data;
  logic       o_valid;
  logic       i_ready;
  logic       o_ovf;
  logic       i_ovf_clr;

  int n_cmp = 0;
  int n_err = 0;

  tt_in_debounce #(
    .WIDTH      (8),
    .DEB_CYCLES (16),
    .FIFO_DEPTH (2)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .io_i_raw  (io_i_raw),
    .o_stable  (o_stable),
    .o_data    (o_data),
    .o_valid   (o_valid),
    .i_ready   (i_ready),
    .o_ovf     (o_ovf),
    .i_ovf_clr (i_ovf_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] raw;
    logic       rdy;
    logic       clr;
    int         cyc;
    logic [7:0] e_stable;
    logic       e_valid;
    logic [7:0] e_data;
    logic       chk_data;
    logic       e_ovf;
  } vec_t;

  localparam int NV = 20;
  vec_t vecs [NV];

  // Advance n rising edges, then settle 1 time unit past the edge
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  initial begin
    // Each row: drive inputs, run cyc edges, compare outputs
    vecs[0]  = '{8'h00, 1'b0, 1'b0, 20, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0}; // quiet after reset
    vecs[1]  = '{8'h01, 1'b0, 1'b0, 10, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0}; // short glitch
    vecs[2]  = '{8'h00, 1'b0, 1'b0, 30, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0}; // back to old level
    vecs[3]  = '{8'h11, 1'b0, 1'b0, 20, 8'h11, 1'b1, 8'h11, 1'b1, 1'b0};
    vecs[4]  = '{8'h22, 1'b0, 1'b0, 20, 8'h22, 1'b1, 8'h11, 1'b1, 1'b0};
    vecs[5]  = '{8'h33, 1'b0, 1'b0, 20, 8'h33, 1'b1, 8'h11, 1'b1, 1'b1}; // dropped
    vecs[6]  = '{8'h33, 1'b1, 1'b0, 1,  8'h33, 1'b1, 8'h22, 1'b1, 1'b1}; // pop 0x11
    vecs[7]  = '{8'h33, 1'b1, 1'b0, 1,  8'h33, 1'b0, 8'h00, 1'b0, 1'b1}; // pop 0x22
    vecs[8]  = '{8'h33, 1'b0, 1'b1, 1,  8'h33, 1'b0, 8'h00, 1'b0, 1'b0}; // clear ovf
    vecs[9]  = '{8'h44, 1'b0, 1'b0, 20, 8'h44, 1'b1, 8'h44, 1'b1, 1'b0};
    vecs[10] = '{8'h55, 1'b0, 1'b0, 20, 8'h55, 1'b1, 8'h44, 1'b1, 1'b0}; // full
    vecs[11] = '{8'h66, 1'b0, 1'b0, 18, 8'h55, 1'b1, 8'h44, 1'b1, 1'b0}; // one edge before push
    vecs[12] = '{8'h66, 1'b1, 1'b0, 1,  8'h66, 1'b1, 8'h55, 1'b1, 1'b0}; // push+pop while full
    vecs[13] = '{8'h66, 1'b1, 1'b0, 1,  8'h66, 1'b1, 8'h66, 1'b1, 1'b0};
    vecs[14] = '{8'h66, 1'b1, 1'b0, 1,  8'h66, 1'b0, 8'h00, 1'b0, 1'b0};
    vecs[15] = '{8'h77, 1'b0, 1'b0, 20, 8'h77, 1'b1, 8'h77, 1'b1, 1'b0};
    vecs[16] = '{8'h88, 1'b0, 1'b0, 20, 8'h88, 1'b1, 8'h77, 1'b1, 1'b0}; // full
    vecs[17] = '{8'h99, 1'b0, 1'b0, 18, 8'h88, 1'b1, 8'h77, 1'b1, 1'b0};
    vecs[18] = '{8'h99, 1'b0, 1'b1, 1,  8'h99, 1'b1, 8'h77, 1'b1, 1'b1}; // drop beats clear
    vecs[19] = '{8'h99, 1'b0, 1'b1, 1,  8'h99, 1'b1, 8'h77, 1'b1, 1'b0}; // clear alone

    // Reset release with 0xA5 already on the pads
    rst_n     = 1'b0;
    io_i_raw  = 8'hA5;
    i_ready   = 1'b0;
    i_ovf_clr = 1'b0;
    step(3);
    check("rst_stable", 32'(o_stable), 32'h00);
    check("rst_data",   32'(o_data),   32'h00);
    check("rst_valid",  32'(o_valid),  32'h0);
    check("rst_ovf",    32'(o_ovf),    32'h0);
    rst_n = 1'b1;
    step(18);
    check("a5_e17_valid",  32'(o_valid),  32'h0);
    check("a5_e17_stable", 32'(o_stable), 32'h00);
    step(1);
    check("a5_e18_valid",  32'(o_valid),  32'h1);
    check("a5_e18_stable", 32'(o_stable), 32'hA5);
    check("a5_e18_data",   32'(o_data),   32'hA5);
    step(30);
    check("a5_hold_stable", 32'(o_stable), 32'hA5);
    check("a5_hold_ovf",    32'(o_ovf),    32'h0);
    i_ready = 1'b1;
    step(1);
    check("a5_single_event", 32'(o_valid), 32'h0);
    i_ready = 1'b0;

    // Fresh reset with quiet pads, then the vector table
    rst_n    = 1'b0;
    io_i_raw = 8'h00;
    step(2);
    rst_n = 1'b1;
    for (int i = 0; i < NV; i++) begin
      io_i_raw  = vecs[i].raw;
      i_ready   = vecs[i].rdy;
      i_ovf_clr = vecs[i].clr;
      step(vecs[i].cyc);
      check($sformatf("v%0d_stable", i), 32'(o_stable), 32'(vecs[i].e_stable));
      check($sformatf("v%0d_valid", i),  32'(o_valid),  32'(vecs[i].e_valid));
      check($sformatf("v%0d_ovf", i),    32'(o_ovf),    32'(vecs[i].e_ovf));
      if (vecs[i].chk_data) begin
        check($sformatf("v%0d_data", i), 32'(o_data), 32'(vecs[i].e_data));
      end
    end
    i_ready   = 1'b0;
    i_ovf_clr = 1'b0;

    // Reset mid-operation with two entries queued (0x77, 0x88)
    rst_n = 1'b0;
    step(1);
    check("mid_rst_valid",  32'(o_valid),  32'h0);
    check("mid_rst_stable", 32'(o_stable), 32'h00);
    check("mid_rst_data",   32'(o_data),   32'h00);
    check("mid_rst_ovf",    32'(o_ovf),    32'h0);
    rst_n = 1'b1;
    step(18);
    check("post_rst_e17_valid", 32'(o_valid), 32'h0);
    step(1);
    check("post_rst_e18_valid",  32'(o_valid),  32'h1);
    check("post_rst_e18_stable", 32'(o_stable), 32'h99);
    check("post_rst_e18_data",   32'(o_data),   32'h99);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
